csa_resolver: RTL

//  Converts a carry-save pair (t, s), as produced by the multiplier's 4:2 adder

---
 rtl/csa_resolver.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/csa_resolver.sv
// -----------------------------------------------------------------------------
// csa_resolver
//   Resolves a carry-save pair (t, s) from the multiplier's 4:2 reduction tree
//   into a single binary sum, sum = t + s. This is an iterative carry-propagate
//   adder. It resolves CHUNK bits per cycle and keeps the carry in a register
//   between cycles, so the carry chain is only CHUNK bits long at the cost of
//   NCH = ceil(N/CHUNK) cycles of latency. It sits between the reduction tree
//   and the rounding stage.
//
// Ports
//   clk        in   1     clock; all state updates on the rising edge
//   rst        in   1     synchronous, active-high reset
//   in_valid   in   1     t/s valid
//   in_ready   out  1     block can accept an operand pair (IDLE only)
//   t          in   N     carry-save carry vector
//   s          in   N     carry-save sum vector
//   out_valid  out  1     sum valid (DONE only)
//   out_ready  in   1     consumer accepts sum
//   sum        out  N+1   t + s; MSB is the carry out of bit N-1
//   busy       out  1     high in ADD or DONE
// -----------------------------------------------------------------------------
module csa_resolver #(
  parameter int N     = 14,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] t,
  input  logic [N-1:0] s,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   sum,
  output logic         busy
);

  localparam int NCH    = (N + CHUNK - 1) / CHUNK;
  // Width of the last, possibly partial, chunk. The true carry out of bit N-1
  // lands at this position of the last chunk's adder output. The operand bits
  // above it are zero.
  localparam int LAST_W = N - (NCH - 1) * CHUNK;
  localparam int KW     = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [N-1:0]   t_q;
  logic [N-1:0]   s_q;
  logic           carry_q;
  logic [KW-1:0]  k_q;

  logic [CHUNK-1:0] t_k;
  logic [CHUNK-1:0] s_k;
  logic [CHUNK:0]   chunk_sum;
  logic [N:0]       sum_next;
  logic             last_chunk;

  // The chunk is selected and written back with constant bit positions,
  // compared against the chunk index. Bits past N-1 are never read, so they
  // are zero, and the results for them are never written back.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first.
    // Otherwise some path leaves it unassigned and a latch is inferred.
    t_k      = '0;
    s_k      = '0;
    sum_next = sum;
    for (int j = 0; j < N; j++) begin
      if (j / CHUNK == int'(k_q)) begin
        t_k[j % CHUNK] = t_q[j];
        s_k[j % CHUNK] = s_q[j];
      end
    end
    chunk_sum = {1'b0, t_k} + {1'b0, s_k} + (CHUNK+1)'(carry_q);
    for (int j = 0; j < N; j++) begin
      if (j / CHUNK == int'(k_q)) begin
        sum_next[j] = chunk_sum[j % CHUNK];
      end
    end
    last_chunk = (k_q == KW'(NCH - 1));
  end

  // in_ready, out_valid and busy are registered. They are decoded from the
  // next state so that they stay aligned with it.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments only. Every flop then
    // samples the values from before the edge, whatever the statement order.
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      carry_q   <= 1'b0;
      k_q       <= '0;
      t_q       <= '0;
      s_q       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            t_q      <= t;
            s_q      <= s;
            carry_q  <= 1'b0;
            k_q      <= '0;
            state    <= ADD;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ADD: begin
          carry_q <= chunk_sum[CHUNK];
          if (last_chunk) begin
            sum       <= {chunk_sum[LAST_W], sum_next[N-1:0]};
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            sum <= sum_next;
            k_q <= k_q + 1'b1;
          end
        end
        DONE: begin
          // The output handshake only returns to IDLE. A new pair is taken
          // no earlier than the following edge.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
